encoder_ctrl: RTL

Frame-level sequencer for the two-stage encoding datapath (stage 1 Q15 precompute registers, stage 2 range update and normalization). It owns the running range register fed to stage 2's `in_range`, generates the stage load enables under downstream backpressure, and runs the frame FSM: init, run, drain, then flush of the carry/bit stage. It sustains one symbol per cycle.

---
 rtl/encoder_ctrl_pkg.sv | 17 +
 rtl/enc_pipe_valid.sv | 38 +++
 rtl/encoder_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/encoder_ctrl_pkg.sv
// Shared types and constants for the encoder frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package encoder_ctrl_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } enc_state_t;

    // Range register start value at the default 16-bit width: only the MSB set
    localparam logic [15:0] RANGE_INIT = 16'h8000;

endpackage

// File: rtl/enc_pipe_valid.sv
// Valid/advance tracking for the stage-1 / stage-2 register pair.
// Latency: a symbol sits in stage 1 the cycle after acceptance and moves to stage 2 on the next unblocked edge.
// Backpressure: m_ready low with stage 2 full freezes stage 2; s_ready drops only when stage 1 cannot move on.
module enc_pipe_valid (
    input  logic clk,
    input  logic reset,
    input  logic stage_open,
    input  logic s_valid,
    input  logic m_ready,
    output logic va,
    output logic vb,
    output logic s1_en,
    output logic s2_en,
    output logic s_ready
);

    logic adv_b;

    // Advance conditions: stage 2 frees when empty or drained; stage 1 frees when it moves forward
    always_comb begin
        adv_b   = !vb || m_ready;
        s2_en   = va && adv_b;
        s_ready = stage_open && (!va || s2_en);
        s1_en   = s_valid && s_ready;
    end

    // Stage valid flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            va <= 1'b0;
            vb <= 1'b0;
        end else begin
            va <= s1_en || (va && !s2_en);
            vb <= s2_en || (vb && !m_ready);
        end
    end

endmodule

// File: rtl/encoder_ctrl.sv
// Frame sequencer for the two-stage encoder: range register, stage load enables, IDLE/RUN/DRAIN/FLUSH FSM.
// Latency: symbol accepted at edge k is valid at the stage-2 output in cycle k+2; one symbol per cycle sustained.
// Backpressure: m_ready combinationally gates s2_en and s_ready (no skid); optional stats under ENCODER_CTRL_STATS_EN.
module encoder_ctrl
    import encoder_ctrl_pkg::*;
#(
    parameter int RANGE_WIDTH = 16,
    parameter int D_SIZE      = 5,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_last,
    output logic                   s1_en,
    output logic                   s2_en,
    input  logic [RANGE_WIDTH-1:0] stage2_out_range,
    output logic [RANGE_WIDTH-1:0] cur_range,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   flush,
    input  logic                   flush_done,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   sym_count,
    output logic [CNT_WIDTH-1:0]   stall_count
);

    // Place the package's MSB-only constant at the top of a 64-bit word, then shift it
    // down so the single set bit lands on bit RANGE_WIDTH-1 for any width
    localparam logic [63:0] RANGE_INIT_64 = {RANGE_INIT, 48'd0} >> (64 - RANGE_WIDTH);
    localparam logic [RANGE_WIDTH-1:0] RANGE_INIT_W = RANGE_INIT_64[RANGE_WIDTH-1:0];

    // Stage 2 owns the normalization shift; a shift field wider than the range is a mis-pairing
    if (D_SIZE > RANGE_WIDTH) begin : g_dsize_exceeds_range
    end

    enc_state_t state_q;
    enc_state_t state_d;
    logic       va;
    logic       vb;
    logic       stage_open;
    logic       start_go;

    assign start_go = (state_q == ST_IDLE) && frame_start;
    assign m_valid  = vb;

    enc_pipe_valid u_pipe (
        .clk        (clk),
        .reset      (reset),
        .stage_open (stage_open),
        .s_valid    (s_valid),
        .m_ready    (m_ready),
        .va         (va),
        .vb         (vb),
        .s1_en      (s1_en),
        .s2_en      (s2_en),
        .s_ready    (s_ready)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: frame_start and flush_done only matter in their own states
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (frame_start)       state_d = ST_RUN;
            ST_RUN:   if (s1_en && s_last)   state_d = ST_DRAIN;
            ST_DRAIN: if (!va && !vb)        state_d = ST_FLUSH;
            ST_FLUSH: if (flush_done)        state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        stage_open = (state_q == ST_RUN);
        flush      = (state_q == ST_FLUSH);
        busy       = (state_q != ST_IDLE);
    end

    // End-of-frame pulse, high for the cycle after flush completion is seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state_q == ST_FLUSH) && flush_done;
        end
    end

    // Running range: reinitialized at frame start, then follows stage 2 on every stage-2 load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_range <= RANGE_INIT_W;
        end else if (start_go) begin
            cur_range <= RANGE_INIT_W;
        end else if (s2_en) begin
            cur_range <= stage2_out_range;
        end
    end

`ifdef ENCODER_CTRL_STATS_EN
    logic [CNT_WIDTH-1:0] sym_q;
    logic [CNT_WIDTH-1:0] stall_q;

    // Per-frame saturating statistics, cleared on an accepted frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_q   <= '0;
            stall_q <= '0;
        end else if (start_go) begin
            sym_q   <= '0;
            stall_q <= '0;
        end else begin
            if (s1_en && (sym_q != '1)) begin
                sym_q <= sym_q + 1'b1;
            end
            if (vb && !m_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign sym_count   = sym_q;
    assign stall_count = stall_q;
`else
    assign sym_count   = '0;
    assign stall_count = '0;
`endif

endmodule
